// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge: FSM states,
// funct3 access-size encodings, timeout defaults and the alignment check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    // funct3[1:0]; funct3[2] only selects sign extension, which the core owns
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W_DEF   = 8;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// bus, and the load word shifted down to bit 0 with upper bits zero.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_shift
);

    always_comb begin
        be          = 4'b1111;
        wdata_lane  = wdata;
        rdata_shift = rdata;
        case (size)
            SZ_BYTE: begin
                be          = 4'b0001 << addr_lo;
                wdata_lane  = {4{wdata[7:0]}};
                rdata_shift = {24'd0, rdata[{addr_lo, 3'b000} +: 8]};
            end
            SZ_HALF: begin
                // addr_lo[0] is ignored: halves are forced to natural alignment
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane  = {2{wdata[15:0]}};
                rdata_shift = {16'd0, (addr_lo[1] ? rdata[31:16] : rdata[15:0])};
            end
            default: begin
                be          = 4'b1111;
                wdata_lane  = wdata;
                rdata_shift = rdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Core data-memory port to valid/ready bus bridge with bus timeout abort.
// Define MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing alignment.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  load_store,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        mem_fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    // Bus handshake: a request transfers in the cycle bus_valid && bus_ready;
    // bus_valid never drops before that except on timeout abort. Read data
    // transfers in the cycle bus_rvalid is high while waiting in RESP.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic              fault_nxt;
    logic              capture;
    logic              zero_rd;
    logic              timeout_hit;
    logic              misalign;
    logic [3:0]        be_lane;
    logic [31:0]       wdata_lane;
    logic [31:0]       rdata_shift;
    logic              unused_sign;

    assign unused_sign = load_store[2];

`ifdef MISALIGN_TRAP_EN
    assign misalign = misaligned(load_store[1:0], Mem_WrAddr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    dmem_lane_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .wdata       (data_q),
        .rdata       (bus_rdata),
        .be          (be_lane),
        .wdata_lane  (wdata_lane),
        .rdata_shift (rdata_shift)
    );

    assign timeout_hit = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        fault_nxt = 1'b0;
        capture   = 1'b0;
        zero_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    if (misalign) begin
                        state_nxt = DONE;
                        fault_nxt = 1'b1;
                        zero_rd   = !mem_we;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                // handshake takes priority over a same-cycle timeout
                if (bus_ready) begin
                    state_nxt = we_q ? DONE : RESP;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    fault_nxt = 1'b1;
                    zero_rd   = !we_q;
                end
            end
            RESP: begin
                if (bus_rvalid) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    fault_nxt = 1'b1;
                    zero_rd   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            cnt       <= '0;
            ReadData  <= '0;
            mem_fault <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_fault <= fault_nxt;
            if (state == IDLE && mem_req) begin
                addr_q <= Mem_WrAddr;
                data_q <= Mem_WrData;
                size_q <= load_store[1:0];
                we_q   <= mem_we;
                cnt    <= '0;
            end else if (state == REQ || state == RESP) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture) begin
                ReadData <= rdata_shift;
            end else if (zero_rd) begin
                ReadData <= '0;
            end
        end
    end

    assign bus_valid = (state == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_be    = (state == REQ) ? be_lane : 4'b0000;
    assign bus_wdata = wdata_lane;
    assign stall     = mem_req && (state != DONE);

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: vector table of single accesses plus
// hand-written waits, timeouts, misalignment, reset abort and mem_req drop.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  load_store = 3'b000;
    logic [31:0] Mem_WrAddr = '0;
    logic [31:0] Mem_WrData = '0;
    logic [31:0] ReadData;
    logic        stall;
    logic        mem_fault;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT(255), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .load_store (load_store),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .ReadData   (ReadData),
        .stall      (stall),
        .mem_fault  (mem_fault),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // per-transaction observations
    int          r_stall;
    int          r_valid_cycles;
    logic        r_seen_valid;
    logic        r_fault;
    logic        r_stable;
    logic        r_done;
    logic        r_valid_after;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rd;
    logic [3:0]  r_be;

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ready_wait, input int rvalid_wait);
        int   rw;
        int   vw;
        logic hs;
        rw = ready_wait;
        vw = rvalid_wait;
        hs = 1'b0;
        r_stall = 0; r_valid_cycles = 0; r_seen_valid = 1'b0; r_fault = 1'b0;
        r_stable = 1'b1; r_done = 1'b0; r_valid_after = 1'b0;
        r_we = 1'b0; r_addr = '0; r_wdata = '0; r_rd = '0; r_be = '0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; load_store = f3;
        Mem_WrAddr = addr; Mem_WrData = wdata; bus_rdata = rdata;
        for (int cyc = 0; cyc < 700; cyc++) begin
            #1;
            if (mem_fault) r_fault = 1'b1;
            if (!stall) begin
                r_done = 1'b1;
                r_rd = ReadData;
                r_valid_after = bus_valid;
                break;
            end
            r_stall++;
            if (bus_valid) begin
                if (!r_seen_valid) begin
                    r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata; r_we = bus_we;
                end else if (bus_addr !== r_addr || bus_be !== r_be ||
                             bus_wdata !== r_wdata || bus_we !== r_we) begin
                    r_stable = 1'b0;
                end
                r_seen_valid = 1'b1;
                r_valid_cycles++;
            end
            bus_ready = 1'b0;
            bus_rvalid = 1'b0;
            if (bus_valid) begin
                if (rw == 0) begin
                    bus_ready = 1'b1;
                    hs = 1'b1;
                end else begin
                    rw--;
                end
            end else if (hs && !we) begin
                if (vw == 0) bus_rvalid = 1'b1;
                else vw--;
            end
            @(negedge clk);
        end
        mem_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        check("txn_completes", {31'd0, r_done}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] last_rd;

    initial begin
        vecs[0] = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 2};
        vecs[1] = '{1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0, 2};
        vecs[2] = '{1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0, 2};
        vecs[3] = '{1'b1, 3'b000, 32'h0000_0001, 32'h0000_007E, 32'h0, 32'h0000_0000, 4'b0010, 32'h7E7E_7E7E, 32'h0, 2};
        vecs[4] = '{1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 32'h0000_0040, 4'b1111, 32'h0, 32'hCAFE_F00D, 3};
        vecs[5] = '{1'b0, 3'b100, 32'h0000_0042, 32'h0, 32'h1122_3344, 32'h0000_0040, 4'b0100, 32'h0, 32'h0000_0022, 3};
        vecs[6] = '{1'b0, 3'b001, 32'h0000_0106, 32'h0, 32'hABCD_1234, 32'h0000_0104, 4'b1100, 32'h0, 32'h0000_ABCD, 3};
        vecs[7] = '{1'b0, 3'b000, 32'h0000_0003, 32'h0, 32'h80FF_FFFF, 32'h0000_0000, 4'b1000, 32'h0, 32'h0000_0080, 3};
        vecs[8] = '{1'b0, 3'b101, 32'h0000_0200, 32'h0, 32'h5555_AAAA, 32'h0000_0200, 4'b0011, 32'h0, 32'h0000_AAAA, 3};
        vecs[9] = '{1'b1, 3'b010, 32'h0000_0080, 32'h0F0F_0F0F, 32'h0, 32'h0000_0080, 4'b1111, 32'h0F0F_0F0F, 32'h0, 2};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_bus_be", {28'd0, bus_be}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_mem_fault", {31'd0, mem_fault}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        last_rd = 32'd0;
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 0);
            if (!vecs[i].we) last_rd = vecs[i].exp_rd;
            check($sformatf("v%0d_addr", i), r_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_be", i), {28'd0, r_be}, {28'd0, vecs[i].exp_be});
            check($sformatf("v%0d_wdata", i), r_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_we", i), {31'd0, r_we}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_stall", i), r_stall, vecs[i].exp_stall);
            check($sformatf("v%0d_readdata", i), r_rd, last_rd);
            check($sformatf("v%0d_fault", i), {31'd0, r_fault}, 32'd0);
        end

        // misaligned LW @0x101
        run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hFEED_FACE, 0, 0);
`ifdef MISALIGN_TRAP_EN
        check("mis_no_valid", {31'd0, r_seen_valid}, 32'd0);
        check("mis_fault", {31'd0, r_fault}, 32'd1);
        check("mis_stall", r_stall, 32'd1);
        check("mis_readdata", r_rd, 32'd0);
`else
        check("mis_addr", r_addr, 32'h0000_0100);
        check("mis_be", {28'd0, r_be}, 32'h0000_000F);
        check("mis_fault", {31'd0, r_fault}, 32'd0);
        check("mis_readdata", r_rd, 32'hFEED_FACE);
`endif

        // LH @0x102 with two rvalid wait cycles
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 2);
        check("lh_wait_rd", r_rd, 32'h0000_8001);
        check("lh_wait_stall", r_stall, 32'd5);
        check("lh_wait_be", {28'd0, r_be}, 32'h0000_000C);
        check("lh_wait_fault", {31'd0, r_fault}, 32'd0);

        // rvalid never arrives: abort in RESP
        run_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h1357_2468, 0, 1000);
        check("resp_to_fault", {31'd0, r_fault}, 32'd1);
        check("resp_to_rd", r_rd, 32'd0);
        check("resp_to_stall", r_stall, 32'd256);

        // rvalid on the last counted cycle wins over the timeout
        run_txn(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h2468_1357, 0, 253);
        check("resp_edge_fault", {31'd0, r_fault}, 32'd0);
        check("resp_edge_rd", r_rd, 32'h2468_1357);
        check("resp_edge_stall", r_stall, 32'd256);

        // bus_ready never asserted
        run_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h9999_9999, 1000, 0);
        check("req_to_fault", {31'd0, r_fault}, 32'd1);
        check("req_to_valid_cycles", r_valid_cycles, 32'd255);
        check("req_to_valid_drop", {31'd0, r_valid_after}, 32'd0);
        check("req_to_rd", r_rd, 32'd0);
        check("req_to_stable", {31'd0, r_stable}, 32'd1);

        // bus_ready on the last counted cycle wins over the timeout
        run_txn(1'b1, 3'b010, 32'h0000_0404, 32'h7777_7777, 32'h0, 254, 0);
        check("req_edge_fault", {31'd0, r_fault}, 32'd0);
        check("req_edge_valid_cycles", r_valid_cycles, 32'd255);
        check("req_edge_stall", r_stall, 32'd256);
        check("req_edge_stable", {31'd0, r_stable}, 32'd1);

        // reset asserted while waiting in RESP
        run_txn(1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'h0BAD_CAFE, 0, 0);
        check("pre_rst_rd", r_rd, 32'h0BAD_CAFE);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; load_store = 3'b010; Mem_WrAddr = 32'h0000_0704;
        @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_resp_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_resp_fault", {31'd0, mem_fault}, 32'd0);
        check("rst_resp_rd", ReadData, 32'd0);
        check("rst_resp_stall", {31'd0, stall}, 32'd1);
        mem_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp_fault_after", {31'd0, mem_fault}, 32'd0);
        check("rst_resp_valid_after", {31'd0, bus_valid}, 32'd0);

        // mem_req dropped mid-transaction keeps the bus request alive
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; load_store = 3'b010;
        Mem_WrAddr = 32'h0000_0800; Mem_WrData = 32'h1111_1111;
        @(negedge clk);
        #1;
        check("drop_valid_0", {31'd0, bus_valid}, 32'd1);
        mem_req = 1'b0;
        @(negedge clk);
        #1;
        check("drop_valid_1", {31'd0, bus_valid}, 32'd1);
        check("drop_addr", bus_addr, 32'h0000_0800);
        check("drop_wdata", bus_wdata, 32'h1111_1111);
        bus_ready = 1'b1;
        @(negedge clk);
        #1;
        bus_ready = 1'b0;
        check("drop_done_valid", {31'd0, bus_valid}, 32'd0);
        check("drop_done_stall", {31'd0, stall}, 32'd0);
        check("drop_done_fault", {31'd0, mem_fault}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
